window_generator_3x3: RTL and testbench

//  Turns a raster-order pixel stream into 3x3 neighbourhood windows for gaussian_operator, sitting directly upstream of it.
//  Two internal line buffers plus a 3x3 register window produce one flat 72-bit kernel word per accepted pixel once the window is fully inside the image.

---
 rtl/hog_pkg.sv | 14 +
 rtl/window_generator_3x3_line_buffer.sv | 26 ++
 rtl/window_generator_3x3.sv | 165 ++++++++++++++++
 tb/tb_window_generator_3x3.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// Shared definitions for the HOG front-end blocks: kernel geometry,
// default pixel width and the row/column to kernel-element mapping.
package hog_pkg;

  localparam int KERNEL_DIM   = 3;
  localparam int KERNEL_ELEMS = KERNEL_DIM * KERNEL_DIM;
  localparam int PIXEL_WIDTH  = 8;

  // Element index inside a flattened kernel; r=0 is the top row, c=0 the left column.
  function automatic int kernel_index(input int r, input int c);
    return (r * KERNEL_DIM) + c;
  endfunction

endpackage

// File: rtl/window_generator_3x3_line_buffer.sv
// One image line of pixel storage: combinational read at addr, write on
// wr_en at the same addr, so a same-cycle read returns the previous line.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[addr];

endmodule

// File: rtl/window_generator_3x3.sv
// Raster pixel stream to 3x3 neighbourhood windows: two line buffers feed a
// register window, and only windows fully inside the image are emitted.
module window_generator_3x3
  import hog_pkg::*;
#(
  parameter int DATA_WIDTH   = PIXEL_WIDTH,
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int KERNEL_WIDTH = KERNEL_ELEMS * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [KERNEL_WIDTH-1:0] kernel,
  output logic                    out_last
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_DIM - 1);

  logic [COL_W-1:0]        col_r;
  logic [COL_W-1:0]        col_next_s;
  logic [ROW_W-1:0]        row_r;
  logic [ROW_W-1:0]        row_next_s;
  logic [DATA_WIDTH-1:0]   win_r      [KERNEL_ELEMS];
  logic [DATA_WIDTH-1:0]   win_next_s [KERNEL_ELEMS];
  logic [DATA_WIDTH-1:0]   lb0_rd_s;
  logic [DATA_WIDTH-1:0]   lb1_rd_s;
  logic [KERNEL_WIDTH-1:0] kernel_r;
  logic [KERNEL_WIDTH-1:0] kernel_next_s;
  logic                    out_valid_r;
  logic                    out_valid_next_s;
  logic                    out_last_r;
  logic                    out_last_next_s;
  logic                    in_ready_s;
  logic                    acc_s;
  logic                    emit_s;
  logic                    win_inside_s;
  logic                    frame_end_s;

  assign in_ready_s   = !out_valid_r || out_ready;
  assign acc_s        = in_valid && in_ready_s;
  assign emit_s       = out_valid_r && out_ready;
  assign win_inside_s = (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
  assign frame_end_s  = (row_r == ROW_LAST) && (col_r == COL_LAST);

  // lb0 holds the previous line, lb1 the one before; lb1 is refilled from lb0's old value.
  line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk     (clk),
    .wr_en   (acc_s),
    .addr    (col_r),
    .wr_data (data_in),
    .rd_data (lb0_rd_s)
  );

  line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (acc_s),
    .addr    (col_r),
    .wr_data (lb0_rd_s),
    .rd_data (lb1_rd_s)
  );

  // Window after this pixel: shift left one column, new right column from the line buffers.
  always_comb begin
    for (int r = 0; r < KERNEL_DIM; r++) begin
      for (int c = 0; c < KERNEL_DIM - 1; c++) begin
        win_next_s[kernel_index(r, c)] = win_r[kernel_index(r, c + 1)];
      end
    end
    win_next_s[kernel_index(0, 2)] = lb1_rd_s;
    win_next_s[kernel_index(1, 2)] = lb0_rd_s;
    win_next_s[kernel_index(2, 2)] = data_in;
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_next_s = col_r;
    row_next_s = row_r;
    if (acc_s) begin
      if (col_r == COL_LAST) begin
        col_next_s = COL_W'(0);
        if (row_r == ROW_LAST) begin
          row_next_s = ROW_W'(0);
        end else begin
          row_next_s = row_r + ROW_W'(1);
        end
      end else begin
        col_next_s = col_r + COL_W'(1);
        row_next_s = row_r;
      end
    end else begin
      col_next_s = col_r;
      row_next_s = row_r;
    end
  end

  // Output stage: a new in-image window replaces the held one, otherwise an emit empties it.
  always_comb begin
    kernel_next_s    = kernel_r;
    out_valid_next_s = out_valid_r;
    out_last_next_s  = out_last_r;
    if (acc_s && win_inside_s) begin
      for (int i = 0; i < KERNEL_ELEMS; i++) begin
        kernel_next_s[i*DATA_WIDTH +: DATA_WIDTH] = win_next_s[i];
      end
      out_valid_next_s = 1'b1;
      out_last_next_s  = frame_end_s;
    end else if (emit_s) begin
      out_valid_next_s = 1'b0;
      out_last_next_s  = 1'b0;
    end else begin
      out_valid_next_s = out_valid_r;
      out_last_next_s  = out_last_r;
    end
  end

  // State registers; the window only moves on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r       <= COL_W'(0);
      row_r       <= ROW_W'(0);
      kernel_r    <= {KERNEL_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      for (int i = 0; i < KERNEL_ELEMS; i++) begin
        win_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      col_r       <= col_next_s;
      row_r       <= row_next_s;
      kernel_r    <= kernel_next_s;
      out_valid_r <= out_valid_next_s;
      out_last_r  <= out_last_next_s;
      if (acc_s) begin
        for (int i = 0; i < KERNEL_ELEMS; i++) begin
          win_r[i] <= win_next_s[i];
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign kernel    = kernel_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_window_generator_3x3.sv
// Self-checking bench for window_generator_3x3 on a 5x4 image: image-level
// reference model plus a table of the expected pattern-frame windows.
module tb_window_generator_3x3;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int KW = 9 * DW;
  localparam int NWIN = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data_in = 8'h00;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic [KW-1:0] kernel;

  always #5 clk = ~clk;

  window_generator_3x3 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .kernel    (kernel),
    .out_last  (out_last)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [KW-1:0] k;
    logic          last;
    int            cyc;
  } win_t;

  typedef struct {
    logic [DW-1:0] k0;
    logic [DW-1:0] k4;
    logic [DW-1:0] k8;
    logic          last;
  } vec_t;

  vec_t tbl [NWIN];

  // Reference model state: image as seen so far and windows still owed.
  bit            mon_en = 1'b0;
  bit            exp_valid = 1'b0;
  int            n_acc = 0;
  int            cyc = 0;
  logic [DW-1:0] img [H][W];
  win_t          exp_q [$];
  win_t          cap_q [$];

  always @(negedge clk) begin
    int            r;
    int            c;
    bit            emit;
    bit            acc;
    logic [KW-1:0] w;
    cyc++;
    if (mon_en) begin
      check("out_valid", KW'(out_valid), KW'(exp_valid));
      check("in_ready", KW'(in_ready), KW'(!exp_valid || out_ready));
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL model_queue: actual=empty expected=pending window");
        end else begin
          check("kernel", kernel, exp_q[0].k);
          check("out_last", KW'(out_last), KW'(exp_q[0].last));
        end
      end
      if (out_valid && out_ready && !rst) begin
        cap_q.push_back('{kernel, out_last, cyc});
      end
      if (rst) begin
        exp_valid = 1'b0;
        n_acc = 0;
        exp_q.delete();
      end else begin
        emit = exp_valid && out_ready;
        acc  = in_valid && (!exp_valid || out_ready);
        if (emit) begin
          void'(exp_q.pop_front());
        end
        if (acc) begin
          r = n_acc / W;
          c = n_acc % W;
          img[r][c] = data_in;
          if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 9; i++) begin
              w[i*DW +: DW] = img[r - 2 + i / 3][c - 2 + i % 3];
            end
            exp_q.push_back('{w, (r == H - 1) && (c == W - 1), 0});
            exp_valid = 1'b1;
          end else if (emit) begin
            exp_valid = 1'b0;
          end
          n_acc = (n_acc + 1) % (W * H);
        end else if (emit) begin
          exp_valid = 1'b0;
        end
      end
    end
  end

  int valid_pct = 100;
  int ready_pct = 100;
  bit pix_mode = 1'b0;
  int src_idx = 0;

  function automatic logic [DW-1:0] pattern_pix(input int idx);
    return 8'(16 * (idx / W) + (idx % W));
  endfunction

  task automatic send(input int npix);
    int sent = 0;
    int guard = 0;
    while (sent < npix && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      in_valid  = ($urandom_range(99) < valid_pct);
      data_in   = pix_mode ? 8'($urandom) : pattern_pix(src_idx);
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        src_idx = (src_idx + 1) % (W * H);
      end
    end
    if (sent < npix) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: actual=%0d expected=%0d pixels", sent, npix);
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", KW'(exp_q.size()), KW'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    src_idx = 0;
    cap_q.delete();
  endtask

  task automatic check_table(input int base, input string tag);
    if (cap_q.size() < base + NWIN) begin
      checks++;
      failures++;
      $display("FAIL %s_count: actual=%0d expected>=%0d", tag, cap_q.size(), base + NWIN);
    end else begin
      for (int i = 0; i < NWIN; i++) begin
        check({tag, "_k0"}, KW'(cap_q[base + i].k[7:0]), KW'(tbl[i].k0));
        check({tag, "_k4"}, KW'(cap_q[base + i].k[39:32]), KW'(tbl[i].k4));
        check({tag, "_k8"}, KW'(cap_q[base + i].k[71:64]), KW'(tbl[i].k8));
        check({tag, "_last"}, KW'(cap_q[base + i].last), KW'(tbl[i].last));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h00, 8'h11, 8'h22, 1'b0};
    tbl[1] = '{8'h01, 8'h12, 8'h23, 1'b0};
    tbl[2] = '{8'h02, 8'h13, 8'h24, 1'b0};
    tbl[3] = '{8'h10, 8'h21, 8'h32, 1'b0};
    tbl[4] = '{8'h11, 8'h22, 8'h33, 1'b0};
    tbl[5] = '{8'h12, 8'h23, 8'h34, 1'b1};

    @(posedge clk); #1;
    mon_en = 1'b1;
    check("reset_kernel", kernel, KW'(0));
    check("reset_last", KW'(out_last), KW'(0));
    do_reset();

    // Full frame at full rate, including per-row throughput.
    valid_pct = 100; ready_pct = 100; pix_mode = 1'b0;
    send(W * H);
    drain();
    check("t1_count", KW'(cap_q.size()), KW'(NWIN));
    check_table(0, "t1");
    if (cap_q.size() >= NWIN) begin
      check("t6_gap01", KW'(cap_q[1].cyc - cap_q[0].cyc), KW'(1));
      check("t6_gap12", KW'(cap_q[2].cyc - cap_q[1].cyc), KW'(1));
      check("t6_gap23", KW'(cap_q[3].cyc - cap_q[2].cyc), KW'(3));
      check("t6_gap34", KW'(cap_q[4].cyc - cap_q[3].cyc), KW'(1));
      check("t6_gap45", KW'(cap_q[5].cyc - cap_q[4].cyc), KW'(1));
    end

    // Downstream stall of 10 cycles right after the first window.
    do_reset();
    send(13);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = pattern_pix(src_idx);
      @(negedge clk);
      check("t2_hold_valid", KW'(out_valid), KW'(1));
      check("t2_hold_ready", KW'(in_ready), KW'(0));
      check("t2_hold_k0", KW'(kernel[7:0]), KW'(tbl[0].k0));
      check("t2_hold_k8", KW'(kernel[71:64]), KW'(tbl[0].k8));
    end
    send(W * H - 13);
    drain();
    check("t2_count", KW'(cap_q.size()), KW'(NWIN));
    check_table(0, "t2");

    // Input gaps.
    do_reset();
    valid_pct = 50;
    send(W * H);
    drain();
    check("t3_count", KW'(cap_q.size()), KW'(NWIN));
    check_table(0, "t3");

    // Two frames back to back.
    do_reset();
    valid_pct = 100;
    send(2 * W * H);
    drain();
    check("t4_count", KW'(cap_q.size()), KW'(2 * NWIN));
    check_table(0, "t4a");
    check_table(NWIN, "t4b");
    if (cap_q.size() > NWIN) begin
      check("t4_repeat", cap_q[NWIN].k, cap_q[0].k);
    end

    // Reset after 7 pixels, then a clean frame.
    do_reset();
    send(7);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    data_in = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    src_idx = 0;
    cap_q.delete();
    @(negedge clk);
    check("t5_valid", KW'(out_valid), KW'(0));
    check("t5_kernel", kernel, KW'(0));
    send(W * H);
    drain();
    check("t5_count", KW'(cap_q.size()), KW'(NWIN));
    check_table(0, "t5");

    // Reset while a window is held.
    do_reset();
    send(13);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    src_idx = 0;
    cap_q.delete();
    @(negedge clk);
    check("t5b_valid", KW'(out_valid), KW'(0));
    check("t5b_kernel", kernel, KW'(0));
    check("t5b_last", KW'(out_last), KW'(0));

    // Random pixels with random handshakes over three frames.
    do_reset();
    pix_mode = 1'b1;
    valid_pct = 70;
    ready_pct = 60;
    send(3 * W * H);
    drain();
    check("rand_count", KW'(cap_q.size()), KW'(3 * NWIN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
